// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: filters the synchronized PLL lock, pulses the PLL reset,
// and releases per-domain active-low resets in staged order once lock is stable.
module pll_lock_supervisor #(
    parameter int N_DOMAINS      = 4,
    parameter int LOCK_FILTER    = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STAGE_GAP      = 16,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 lock,
    input  logic                 sw_rst_req,
    output logic                 pll_reset,
    output logic [N_DOMAINS-1:0] rst_n_o,
    output logic                 ready,
    output logic [CNT_W-1:0]     lock_loss_cnt,
    output logic [CNT_W-1:0]     timeout_cnt,
    output logic [1:0]           state_o
);

    localparam int MAX_A = (LOCK_TIMEOUT > LOCK_FILTER) ? LOCK_TIMEOUT : LOCK_FILTER;
    localparam int MAX_B = (PLL_RST_CYCLES > STAGE_GAP) ? PLL_RST_CYCLES : STAGE_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_P + 1);
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state;
    logic             lock_sync_p0;
    logic             lock_q;
    logic [TW-1:0]    phase_cnt;
    logic [TW-1:0]    filt_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [IDX_W-1:0] stage_idx;

    logic filt_done;
    logic tmo_hit;
    logic lost;
    logic sw_abort;
    logic tmo_abort;
    logic abort;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign state_o   = state;
    assign filt_done = lock_q && (filt_cnt == TW'(LOCK_FILTER - 1));
    assign tmo_hit   = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
    assign lost      = !lock_q && ((state == RELEASE) || (state == RUN));
    assign sw_abort  = sw_rst_req && (state != PLL_RST);
    // The filter wins a tie with the timeout; a software request masks both event counters.
    assign tmo_abort = (state == WAIT_LOCK) && tmo_hit && !filt_done;
    assign abort     = sw_abort || lost || tmo_abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= PLL_RST;
            pll_reset     <= 1'b1;
            rst_n_o       <= '0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
            lock_sync_p0  <= 1'b0;
            lock_q        <= 1'b0;
            phase_cnt     <= '0;
            filt_cnt      <= '0;
            tmo_cnt       <= '0;
            stage_idx     <= '0;
        end else begin
            lock_sync_p0 <= lock;
            lock_q       <= lock_sync_p0;

            if (!sw_abort && lost)
                lock_loss_cnt <= sat_inc(lock_loss_cnt);
            if (!sw_abort && tmo_abort)
                timeout_cnt <= sat_inc(timeout_cnt);

            if (abort) begin
                state     <= PLL_RST;
                pll_reset <= 1'b1;
                rst_n_o   <= '0;
                ready     <= 1'b0;
                phase_cnt <= '0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (phase_cnt == TW'(PLL_RST_CYCLES - 1)) begin
                            state     <= WAIT_LOCK;
                            pll_reset <= 1'b0;
                            phase_cnt <= '0;
                            filt_cnt  <= '0;
                            tmo_cnt   <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (filt_done) begin
                            state     <= RELEASE;
                            rst_n_o   <= N_DOMAINS'(1);
                            phase_cnt <= '0;
                            stage_idx <= '0;
                        end else begin
                            filt_cnt <= lock_q ? filt_cnt + 1'b1 : '0;
                            tmo_cnt  <= tmo_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        // phase_cnt times the gap since the most recently released domain.
                        if (phase_cnt == TW'(STAGE_GAP - 1)) begin
                            phase_cnt <= '0;
                            if (stage_idx == IDX_W'(N_DOMAINS - 1)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end else begin
                                stage_idx                     <= stage_idx + 1'b1;
                                rst_n_o[stage_idx + 1'b1]     <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        ready   <= 1'b1;
                        rst_n_o <= '1;
                    end
                    default: begin
                        state     <= PLL_RST;
                        pll_reset <= 1'b1;
                        rst_n_o   <= '0;
                        ready     <= 1'b0;
                        phase_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: bring-up table, hand-written corner
// sequences and randomized lock/sw stimulus against a timeline-based reference model.
module tb_pll_lock_supervisor;

    localparam int N   = 4;
    localparam int LF  = 8;
    localparam int LT  = 64;
    localparam int PRC = 4;
    localparam int GAP = 2;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          lock;
    logic          sw_rst_req;
    logic          pll_reset;
    logic [N-1:0]  rst_n_o;
    logic          ready;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;
    logic [1:0]    state_o;

    int checks   = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .N_DOMAINS(N), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
        .PLL_RST_CYCLES(PRC), .STAGE_GAP(GAP), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .lock(lock), .sw_rst_req(sw_rst_req),
        .pll_reset(pll_reset), .rst_n_o(rst_n_o), .ready(ready),
        .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference model: mode numbers follow the externally visible state_o values;
    // age counts edges spent in the current mode, run counts consecutive lock_q highs.
    int         m_mode, m_age, m_run, m_loss, m_tmo;
    logic       m_s0, m_s1;
    logic [3:0] m_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_run = 0; m_loss = 0; m_tmo = 0;
        m_s0 = 1'b0; m_s1 = 1'b0; m_rst = 4'b0000;
    endtask

    task automatic enter(input int m);
        m_mode = m; m_age = 0; m_run = 0;
        if (m == 0) m_rst = 4'b0000;
        if (m == 2) m_rst = 4'b0001;
    endtask

    task automatic model_step(input logic l, input logic s);
        logic lq;
        int   a;
        bit   go_rst;
        lq = m_s1;
        a = m_age + 1;
        go_rst = 0;
        if (m_mode != 0 && s) go_rst = 1;
        else if (m_mode == 0) begin
            if (a == PRC) enter(1); else m_age = a;
        end else if (m_mode == 1) begin
            m_run = lq ? m_run + 1 : 0;
            if (m_run >= LF) enter(2);
            else if (a == LT) begin
                if (m_tmo < 255) m_tmo++;
                go_rst = 1;
            end else m_age = a;
        end else if (!lq) begin
            if (m_loss < 255) m_loss++;
            go_rst = 1;
        end else if (m_mode == 2) begin
            for (int k = 0; k < N; k++) if (a >= k * GAP) m_rst[k] = 1'b1;
            if (a == N * GAP) enter(3); else m_age = a;
        end
        if (go_rst) enter(0);
        m_s1 = m_s0;
        m_s0 = l;
    endtask

    task automatic check_model();
        chk("pll_reset", pll_reset, (m_mode == 0));
        chk("rst_n_o", rst_n_o, m_rst);
        chk("ready", ready, (m_mode == 3));
        chk("state_o", state_o, m_mode);
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
        chk("timeout_cnt", timeout_cnt, m_tmo);
    endtask

    task automatic tick(input logic l, input logic s);
        lock = l;
        sw_rst_req = s;
        @(posedge clk);
        model_step(l, s);
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_pll_reset", pll_reset, 1);
        chk("async_rst_n_o", rst_n_o, 0);
        chk("async_ready", ready, 0);
        chk("async_state", state_o, 0);
        chk("async_loss_cnt", lock_loss_cnt, 0);
        chk("async_tmo_cnt", timeout_cnt, 0);
        model_reset();
        sw_rst_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick(1'b1, 1'b0);
            if (ready) found = 1;
        end
        chk(name, found, 1);
    endtask

    task automatic wait_rst(input string name, input logic [3:0] val, input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick(1'b1, 1'b0);
            if (rst_n_o == val) found = 1;
        end
        chk(name, found, 1);
    endtask

    typedef struct {
        int         ed;
        logic       pr;
        logic [3:0] rn;
        logic       rdy;
        logic [1:0] st;
    } vec_t;

    vec_t vec[12];

    initial begin
        int pr_cycles;
        int rises;
        logic prev;

        // Value after edge ed (spec cycle ed+1) during a clean bring-up with lock tied high.
        vec[0]  = '{1,  1'b1, 4'h0, 1'b0, 2'd0};
        vec[1]  = '{3,  1'b1, 4'h0, 1'b0, 2'd0};
        vec[2]  = '{4,  1'b0, 4'h0, 1'b0, 2'd1};
        vec[3]  = '{11, 1'b0, 4'h0, 1'b0, 2'd1};
        vec[4]  = '{12, 1'b0, 4'h1, 1'b0, 2'd2};
        vec[5]  = '{13, 1'b0, 4'h1, 1'b0, 2'd2};
        vec[6]  = '{14, 1'b0, 4'h3, 1'b0, 2'd2};
        vec[7]  = '{16, 1'b0, 4'h7, 1'b0, 2'd2};
        vec[8]  = '{18, 1'b0, 4'hF, 1'b0, 2'd2};
        vec[9]  = '{19, 1'b0, 4'hF, 1'b0, 2'd2};
        vec[10] = '{20, 1'b0, 4'hF, 1'b1, 2'd3};
        vec[11] = '{25, 1'b0, 4'hF, 1'b1, 2'd3};

        resetn = 1'b0;
        lock = 1'b0;
        sw_rst_req = 1'b0;
        model_reset();
        #22;
        apply_reset();

        // Clean bring-up
        for (int e = 1; e <= 25; e++) begin
            tick(1'b1, 1'b0);
            for (int i = 0; i < 12; i++) begin
                if (vec[i].ed == e) begin
                    chk("bringup_pll_reset", pll_reset, vec[i].pr);
                    chk("bringup_rst_n_o", rst_n_o, vec[i].rn);
                    chk("bringup_ready", ready, vec[i].rdy);
                    chk("bringup_state", state_o, vec[i].st);
                end
            end
        end

        // Lock loss in RUN: 3 low cycles, abort visible on the third edge
        tick(1'b0, 1'b0);
        chk("loss_ready_hold1", ready, 1);
        tick(1'b0, 1'b0);
        chk("loss_ready_hold2", ready, 1);
        tick(1'b0, 1'b0);
        chk("loss_rst_n_o", rst_n_o, 0);
        chk("loss_ready", ready, 0);
        chk("loss_pll_reset", pll_reset, 1);
        chk("loss_cnt", lock_loss_cnt, 1);
        pr_cycles = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            if (pll_reset) pr_cycles++;
        end
        chk("loss_pll_pulse_width", pr_cycles, PRC);
        wait_ready("loss_rerelease", 40);

        // sw_rst_req mid-RELEASE
        tick(1'b1, 1'b1);
        chk("sw_run_state", state_o, 0);
        wait_rst("sw_reach_0011", 4'b0011, 40);
        tick(1'b1, 1'b1);
        chk("sw_rel_rst_n_o", rst_n_o, 0);
        chk("sw_rel_state", state_o, 0);
        chk("sw_rel_loss_cnt", lock_loss_cnt, 1);
        chk("sw_rel_tmo_cnt", timeout_cnt, 0);

        // sw_rst_req in the same cycle as lock loss
        wait_ready("sw_loss_ready", 40);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("sw_loss_state", state_o, 0);
        chk("sw_loss_cnt", lock_loss_cnt, 1);
        wait_ready("sw_loss_recover", 40);

        // Lock chatter during WAIT_LOCK
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            tick(((c / 5) % 2) == 1, 1'b0);
            chk("chatter_no_release", rst_n_o, 0);
        end
        wait_ready("chatter_release", 40);
        chk("chatter_loss_cnt", lock_loss_cnt, 0);

        // Randomized lock drops and software requests
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 99) < 97, $urandom_range(0, 199) == 0);

        // Async reset while in RUN
        wait_ready("async_run_reached", 80);
        apply_reset();

        // Repeated timeouts up to saturation
        prev = 1'b1;
        rises = 0;
        for (int i = 0; i < 300 * (PRC + LT); i++) begin
            tick(1'b0, 1'b0);
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
        end
        chk("timeout_pulses", rises, 300);
        chk("timeout_saturated", timeout_cnt, 255);
        chk("timeout_loss_cnt", lock_loss_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits on the output side of the board PLL wrapper and runs on the free-running PLL input reference clock.
- Synchronizes and filters the PLL lock output, then drives the PLL reset pin.
- Releases per-domain active-low resets in staged order once lock is stable.
- On lock loss, lock timeout or software request: reasserts all resets at once and restarts the PLL.

Parameters:
N_DOMAINS, 4, number of staged reset outputs (1..8)
LOCK_FILTER, 1024, consecutive synchronized lock-high cycles required before release (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before forcing a PLL reset (> LOCK_FILTER)
PLL_RST_CYCLES, 16, pll_reset pulse width in cycles (>=1)
STAGE_GAP, 16, cycles between successive reset releases (>=1)
CNT_W, 8, width of the event counters

Ports:
clk  in  1  free-running reference clock (PLL input clock)
resetn  in  1  asynchronous active-low reset
lock  in  1  PLL lock; asynchronous to clk
sw_rst_req  in  1  single-cycle software restart request
pll_reset  out  1  active-high reset to the PLL
rst_n_o  out  N_DOMAINS  staged active-low domain resets, registered
ready  out  1  all domains out of reset, lock good
lock_loss_cnt  out  CNT_W  lock-loss events while released, saturating
timeout_cnt  out  CNT_W  lock-timeout events, saturating
state_o  out  2  0=PLL_RST 1=WAIT_LOCK 2=RELEASE 3=RUN

Behaviour:
- Clock and reset: one clock domain. resetn is asynchronous assert, synchronous deassert handled upstream; all flops clear on resetn=0.
- Reset values:
  - state=PLL_RST, pll_reset=1, rst_n_o=0, ready=0.
  - Both counters=0; lock synchronizer flops=0; all internal counters=0.
- Synchronizer: lock passes through a 2-flop synchronizer to give lock_q. Only lock_q is used.
- PLL_RST:
  - pll_reset=1, rst_n_o=0, ready=0.
  - Holds exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with the filter and timeout counters cleared.
- WAIT_LOCK:
  - pll_reset=0.
  - Filter counter increments each cycle lock_q=1 and clears to 0 on lock_q=0.
  - Timeout counter increments every cycle.
  - After LOCK_FILTER consecutive lock_q=1 cycles, go to RELEASE.
  - Otherwise, when the timeout counter reaches LOCK_TIMEOUT, timeout_cnt++ (saturating) and go to PLL_RST.
  - If the filter completes and the timeout hits in the same cycle, the filter wins.
- RELEASE:
  - rst_n_o[0] rises on the first cycle in RELEASE.
  - rst_n_o[k] rises k*STAGE_GAP cycles after rst_n_o[0].
  - STAGE_GAP cycles after rst_n_o[N_DOMAINS-1] rises, go to RUN.
  - Released bits stay high until an abort.
- RUN: ready=1, all rst_n_o=1.
- Lock loss (lock_q=0 in RELEASE or RUN):
  - Next cycle: rst_n_o=0, ready=0, state=PLL_RST.
  - lock_loss_cnt++ (saturating at 2^CNT_W-1).
  - Lock drop in WAIT_LOCK is not counted; it only clears the filter.
- sw_rst_req=1 in any state except PLL_RST:
  - Next cycle: state=PLL_RST, all resets asserted, no counter increments.
  - Ignored while already in PLL_RST (the pulse is not extended).
- Simultaneous events in the same cycle: sw_rst_req has priority over lock loss (not counted), and lock loss has priority over stage advance.
- Counters: never wrap; cleared only by resetn.
- Glitch rule: all outputs are registered, so no combinational paths from inputs to outputs.
- Implementation: counter widths are sized by $clog2 of the largest parameter.

Test Plan:
Bench parameters for all scenarios: N_DOMAINS=4, LOCK_FILTER=8, LOCK_TIMEOUT=64, PLL_RST_CYCLES=4, STAGE_GAP=2, CNT_W=8. Cycle 1 is the first clk edge after resetn rises.
- Clean bring-up: lock tied 1 -> pll_reset=1 on cycles 1-4; rst_n_o[0..3] rise at cycles 13/15/17/19; ready=1 at cycle 21; state_o=3; both counters 0.
- Lock chatter: lock toggles every 5 cycles during WAIT_LOCK, then stays high -> no release until 8 consecutive lock_q=1; lock_loss_cnt stays 0.
- Lock loss in RUN: drop lock for 3 cycles -> 3 cycles after lock falls (2 sync + 1), rst_n_o=0000, ready=0, pll_reset=1 for 4 cycles; lock_loss_cnt=1; full re-release sequence follows.
- Timeout: lock held 0 -> pll_reset pulses every 68 cycles; timeout_cnt increments each time; force 300 timeouts -> timeout_cnt saturates at 255.
- sw_rst_req mid-RELEASE (after rst_n_o=0011) -> next cycle rst_n_o=0000, state_o=0, counters unchanged. Same-cycle sw_rst_req plus lock loss -> lock_loss_cnt unchanged.
- Async reset in RUN: drop resetn mid-cycle -> outputs return to reset values immediately, without waiting for a clk edge.
